vector_mac_acc: RTL and testbench

//  Pipelined VLEN-lane signed dot-product unit with temporal accumulation.

---
 rtl/vector_mac_acc_pkg.sv | 18 +
 rtl/vector_mac_acc_if.sv | 37 +++
 rtl/vector_mac_acc_round_sat.sv | 44 ++++
 rtl/vector_mac_acc.sv | 139 +++++++++++++
 tb/tb_vector_mac_acc.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vector_mac_acc_pkg.sv
// Shared types and sizing helpers for the vector MAC accumulator.
package vmac_pkg;

  localparam int unsigned SHIFT_MAX_W = 8;

  // Control metadata that travels alongside the datapath through each stage.
  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [SHIFT_MAX_W-1:0] shift;
  } stage_meta_t;

  function automatic int unsigned acc_width(input int unsigned a_w, input int unsigned b_w,
                                            input int unsigned vlen, input int unsigned beats);
    return a_w + b_w + 32'($clog2(vlen)) + 32'($clog2(beats));
  endfunction

endpackage

// File: rtl/vector_mac_acc_if.sv
// Operand-in / result-out handshake bundle for vector_mac_acc.
interface vector_mac_acc_if
  import vmac_pkg::*;
#(
  parameter int unsigned A_WIDTH      = 16,
  parameter int unsigned B_WIDTH      = 16,
  parameter int unsigned VLEN         = 36,
  parameter int unsigned MAX_BEATS    = 64,
  parameter int unsigned OUTPUT_WIDTH = 32
) ();

  localparam int unsigned ACC_WIDTH = acc_width(A_WIDTH, B_WIDTH, VLEN, MAX_BEATS);
  localparam int unsigned SHIFT_W   = $clog2(ACC_WIDTH);

  logic                               in_valid;
  logic                               in_ready;
  logic                               in_last;
  logic [VLEN-1:0][A_WIDTH-1:0]       a;
  logic [VLEN-1:0][B_WIDTH-1:0]       b;
  logic [SHIFT_W-1:0]                 cfg_shift;
  logic                               out_valid;
  logic                               out_ready;
  logic [OUTPUT_WIDTH-1:0]            out_data;
  logic                               out_sat;
  logic                               out_ovf;

  modport master (
    output in_valid, in_last, a, b, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_ovf
  );

  modport slave (
    input  in_valid, in_last, a, b, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_ovf
  );

endinterface

// File: rtl/vector_mac_acc_round_sat.sv
// Round-half-up arithmetic right shift followed by optional clamp to OUT_WIDTH.
module round_sat #(
  parameter int unsigned IN_WIDTH  = 44,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT_W   = 6,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic signed [IN_WIDTH-1:0]  in_val,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic        [OUT_WIDTH-1:0] out_val_c,
  output logic                        sat_c
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned EW = IN_WIDTH + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext_c;
  logic signed [EW-1:0] rnd_c;
  logic signed [EW-1:0] rounded_c;

  always_comb begin
    ext_c = EW'(in_val);
    rnd_c = '0;
    if (shift != '0) begin
      rnd_c = EW'(1) << (shift - SHIFT_W'(1));
    end
    rounded_c = (ext_c + rnd_c) >>> shift;

    out_val_c = rounded_c[OUT_WIDTH-1:0];
    sat_c     = 1'b0;
    if (SATURATE) begin
      if (rounded_c > MAX_V) begin
        out_val_c = MAX_V[OUT_WIDTH-1:0];
        sat_c     = 1'b1;
      end else if (rounded_c < MIN_V) begin
        out_val_c = MIN_V[OUT_WIDTH-1:0];
        sat_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_mac_acc.sv
// Pipelined VLEN-lane signed dot product with per-group accumulation and
// rounded/saturated result delivery over a valid/ready output.
module vector_mac_acc
  import vmac_pkg::*;
#(
  parameter int unsigned A_WIDTH      = 16,
  parameter int unsigned B_WIDTH      = 16,
  parameter int unsigned VLEN         = 36,
  parameter int unsigned MAX_BEATS    = 64,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter bit          SATURATE     = 1'b1
) (
  input logic              clk,
  input logic              arst_in,
  vector_mac_acc_if.slave  bus
);

  localparam int unsigned ACC_WIDTH = acc_width(A_WIDTH, B_WIDTH, VLEN, MAX_BEATS);
  localparam int unsigned SHIFT_W   = $clog2(ACC_WIDTH);
  localparam int unsigned PROD_W    = A_WIDTH + B_WIDTH;
  localparam int unsigned SUM_W     = PROD_W + $clog2(VLEN);
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 2);

  logic                          advance_c;
  stage_meta_t                   s1_meta_q, s1_meta_d;
  stage_meta_t                   s2_meta_q, s2_meta_d;
  logic signed [PROD_W-1:0]      prod_q [VLEN];
  logic signed [PROD_W-1:0]      prod_d [VLEN];
  logic signed [SUM_W-1:0]       sum_q, sum_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, acc_next_c;
  logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_next_c;
  logic                          out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0]       out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          out_ovf_q, out_ovf_d;
  logic [OUTPUT_WIDTH-1:0]       rs_data_c;
  logic                          rs_sat_c;

  // A held result freezes the whole pipe, including the input.
  assign advance_c     = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_ovf   = out_ovf_q;

  // S1 lane products and S2 flat adder tree.
  always_comb begin
    s1_meta_d = s1_meta_q;
    s2_meta_d = s2_meta_q;
    sum_d     = sum_q;
    for (int i = 0; i < int'(VLEN); i++) begin
      prod_d[i] = prod_q[i];
    end
    if (advance_c) begin
      s1_meta_d = '{valid: bus.in_valid, last: bus.in_last, shift: SHIFT_MAX_W'(bus.cfg_shift)};
      for (int i = 0; i < int'(VLEN); i++) begin
        prod_d[i] = PROD_W'($signed(bus.a[i])) * PROD_W'($signed(bus.b[i]));
      end
      s2_meta_d = s1_meta_q;
      sum_d     = '0;
      for (int i = 0; i < int'(VLEN); i++) begin
        sum_d = sum_d + SUM_W'(prod_q[i]);
      end
    end
  end

  round_sat #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUTPUT_WIDTH),
    .SHIFT_W   (SHIFT_W),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .in_val    (acc_next_c),
    .shift     (SHIFT_W'(s2_meta_q.shift)),
    .out_val_c (rs_data_c),
    .sat_c     (rs_sat_c)
  );

  // S3: accumulate, count beats, and load the result register on a last beat.
  // The accumulator is zero at every group start, so the first beat adds to 0.
  always_comb begin
    acc_next_c  = acc_q + ACC_WIDTH'(sum_q);
    cnt_next_c  = (cnt_q > CNT_W'(MAX_BEATS)) ? cnt_q : cnt_q + CNT_W'(1);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_ovf_d   = out_ovf_q;
    if (advance_c) begin
      out_valid_d = 1'b0;
      if (s2_meta_q.valid) begin
        if (s2_meta_q.last) begin
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = rs_data_c;
          out_sat_d   = rs_sat_c;
          out_ovf_d   = (cnt_next_c > CNT_W'(MAX_BEATS));
        end else begin
          acc_d = acc_next_c;
          cnt_d = cnt_next_c;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      s1_meta_q   <= '0;
      s2_meta_q   <= '0;
      sum_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      for (int i = 0; i < int'(VLEN); i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      s1_meta_q   <= s1_meta_d;
      s2_meta_q   <= s2_meta_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_ovf_q   <= out_ovf_d;
      for (int i = 0; i < int'(VLEN); i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_acc.sv
// Directed bench for vector_mac_acc: single-beat vector table plus
// multi-beat, stall, reset and overflow sequences.
module tb_vector_mac_acc;

  localparam int unsigned AW = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned VL = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned OW = 16;
  localparam int unsigned NV = 11;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          exp_data;
    logic        exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic arst_in;
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t vt [NV];

  always #5 clk = ~clk;

  vector_mac_acc_if #(.A_WIDTH(AW), .B_WIDTH(BW), .VLEN(VL), .MAX_BEATS(MB),
                      .OUTPUT_WIDTH(OW)) bus ();

  vector_mac_acc #(.A_WIDTH(AW), .B_WIDTH(BW), .VLEN(VL), .MAX_BEATS(MB),
                   .OUTPUT_WIDTH(OW), .SATURATE(1'b1)) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus)
  );

  function automatic logic [31:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic last, input logic [4:0] sh);
    int guard = 0;
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.in_last   = last;
    bus.cfg_shift = sh;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(output int data, output logic sat, output logic ovf, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    data = int'($signed(bus.out_data));
    sat  = bus.out_sat;
    ovf  = bus.out_ovf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   d, lat, extra;
    logic s, o;

    vt[0]  = '{lanes(1, 2, 3, 4),         lanes(5, 6, 7, 8),         5'd0, 70,     1'b0};
    vt[1]  = '{lanes(1, 2, 3, 4),         lanes(5, 6, 7, 8),         5'd2, 18,     1'b0};
    vt[2]  = '{lanes(-1, -2, -3, -4),     lanes(5, 6, 7, 8),         5'd2, -17,    1'b0};
    vt[3]  = '{lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), 5'd0, 32767,  1'b1};
    vt[4]  = '{lanes(-128, -128, -128, -128), lanes(127, 127, 127, 127), 5'd0, -32768, 1'b1};
    vt[5]  = '{lanes(-128, -128, -128, -128), lanes(-128, -128, -128, -128), 5'd1, 32767, 1'b1};
    vt[6]  = '{lanes(10, -20, 30, -40),   lanes(3, 3, 3, 3),         5'd0, -60,    1'b0};
    vt[7]  = '{lanes(100, 100, 0, 0),     lanes(100, 100, 0, 0),     5'd3, 2500,   1'b0};
    vt[8]  = '{lanes(1, 0, 0, 0),         lanes(1, 0, 0, 0),         5'd1, 1,      1'b0};
    vt[9]  = '{lanes(-1, 0, 0, 0),        lanes(1, 0, 0, 0),         5'd1, 0,      1'b0};
    vt[10] = '{lanes(-3, 0, 0, 0),        lanes(1, 0, 0, 0),         5'd1, -1,     1'b0};

    arst_in       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cfg_shift = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 0);
    check("rst out_data", 64'(bus.out_data), 0);
    check("rst out_sat", 64'(bus.out_sat), 0);
    check("rst out_ovf", 64'(bus.out_ovf), 0);
    arst_in = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 64'(bus.in_ready), 1);

    // Single-beat groups from the table
    for (int i = 0; i < int'(NV); i++) begin
      send_beat(vt[i].a, vt[i].b, 1'b1, vt[i].sh);
      get_result(d, s, o, lat);
      check($sformatf("vec%0d data", i), d, vt[i].exp_data);
      check($sformatf("vec%0d sat", i), 64'(s), 64'(vt[i].exp_sat));
      check($sformatf("vec%0d ovf", i), 64'(o), 0);
      check($sformatf("vec%0d latency", i), lat, 3);
    end

    // Three-beat saturating group: 3*64516 = 193548
    for (int k = 0; k < 3; k++) begin
      send_beat(lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), k == 2, 5'd0);
    end
    get_result(d, s, o, lat);
    check("grp3 data", d, 32767);
    check("grp3 sat", 64'(s), 1);
    check("grp3 ovf", 64'(o), 0);

    // Bubble inside a group; shift on the non-last beat must be ignored
    send_beat(lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b0, 5'd3);
    @(negedge clk);
    send_beat(lanes(1, 1, 1, 1), lanes(2, 2, 2, 2), 1'b1, 5'd0);
    get_result(d, s, o, lat);
    check("bubble data", d, 78);
    check("bubble sat", 64'(s), 0);

    // Back-pressure with two results in flight
    bus.out_ready = 1'b0;
    send_beat(lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b1, 5'd0);
    send_beat(lanes(10, -20, 30, -40), lanes(3, 3, 3, 3), 1'b1, 5'd0);
    repeat (5) @(negedge clk);
    check("stall in_ready", 64'(bus.in_ready), 0);
    check("stall out_valid", 64'(bus.out_valid), 1);
    check("stall out_data", int'($signed(bus.out_data)), 70);
    repeat (3) @(negedge clk);
    check("stall data held", int'($signed(bus.out_data)), 70);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    get_result(d, s, o, lat);
    check("stall 2nd data", d, -60);
    check("stall 2nd latency", lat, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check("stall no duplicate", extra, 0);

    // Reset in the middle of a group discards the partial sum
    send_beat(lanes(10, 10, 10, 10), lanes(10, 10, 10, 10), 1'b0, 5'd0);
    send_beat(lanes(10, 10, 10, 10), lanes(10, 10, 10, 10), 1'b0, 5'd0);
    @(negedge clk);
    #2 arst_in = 1'b1;
    #2;
    check("midrst out_valid", 64'(bus.out_valid), 0);
    @(negedge clk);
    arst_in = 1'b0;
    send_beat(lanes(1, 1, 1, 1), lanes(2, 2, 2, 2), 1'b1, 5'd0);
    get_result(d, s, o, lat);
    check("midrst data", d, 8);
    check("midrst ovf", 64'(o), 0);

    // Five beats exceeds MAX_BEATS; four beats is the boundary
    for (int k = 0; k < 5; k++) begin
      send_beat(lanes(1, 0, 0, 0), lanes(1, 0, 0, 0), k == 4, 5'd0);
    end
    get_result(d, s, o, lat);
    check("ovf5 data", d, 5);
    check("ovf5 ovf", 64'(o), 1);
    for (int k = 0; k < 4; k++) begin
      send_beat(lanes(1, 0, 0, 0), lanes(1, 0, 0, 0), k == 3, 5'd0);
    end
    get_result(d, s, o, lat);
    check("ovf4 data", d, 4);
    check("ovf4 ovf", 64'(o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
